// File: rtl/bram18_wide_writer.sv
`default_nettype none
// bram18_wide_writer: serializes one masked 72-bit word into 18-bit writes on BRAM port A.
// Lane k of a word at S_ADDR is written to S_ADDR + k*BASE_ADDRESS (mod 2^ADDR_WIDTH).
module bram18_wide_writer #(
  parameter int DATA_WIDTH_A = 18,
  parameter int LANES        = 4,
  parameter int ADDR_WIDTH   = 11,
  parameter int BASE_ADDRESS = 512,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [LANES*DATA_WIDTH_A-1:0] S_DATA,
  input  logic [ADDR_WIDTH-3:0]         S_ADDR,
  input  logic [LANES-1:0]              S_MASK,
  input  logic                          S_VALID,
  output logic                          S_READY,
  output logic [DATA_WIDTH_A-1:0]       DIN_A,
  output logic [ADDR_WIDTH-1:0]         ADDR_A,
  output logic                          W_A,
  output logic                          EN_A,
  output logic                          DONE,
  output logic [CNT_WIDTH-1:0]          WORD_COUNT
);

  localparam int c_wide_w = LANES * DATA_WIDTH_A;
  localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_stride   = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [LANES-1:0]      c_lane_one = LANES'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  r_state, w_state_next;
  logic [c_wide_w-1:0]     r_data, w_data_next;
  logic [ADDR_WIDTH-3:0]   r_addr, w_addr_next;
  logic [LANES-1:0]        r_pend, w_pend_next;
  logic                    r_wr, w_wr_next;
  logic                    w_ready_next, w_done_next;
  logic [DATA_WIDTH_A-1:0] w_din_next;
  logic [ADDR_WIDTH-1:0]   w_addr_a_next;
  logic [CNT_WIDTH-1:0]    w_count_next;
  logic                    w_issue;
  logic [c_wide_w-1:0]     w_src_data;
  logic [ADDR_WIDTH-3:0]   w_src_addr;
  logic [LANES-1:0]        w_src_mask;
  logic [c_lane_w-1:0]     w_lane;

  function automatic logic [c_lane_w-1:0] lowest_set(input logic [LANES-1:0] m);
    lowest_set = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = c_lane_w'(k);
    end
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_addr     <= '0;
      r_pend     <= '0;
      r_wr       <= 1'b0;
      S_READY    <= 1'b0;
      DIN_A      <= '0;
      ADDR_A     <= '0;
      DONE       <= 1'b0;
      WORD_COUNT <= '0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_addr     <= w_addr_next;
      r_pend     <= w_pend_next;
      r_wr       <= w_wr_next;
      S_READY    <= w_ready_next;
      DIN_A      <= w_din_next;
      ADDR_A     <= w_addr_a_next;
      DONE       <= w_done_next;
      WORD_COUNT <= w_count_next;
    end
  end

  // The first lane is issued straight from the request inputs on the acceptance
  // edge so its write lands one edge later; r_pend holds lanes still to be issued.
  always_comb begin
    w_state_next  = r_state;
    w_data_next   = r_data;
    w_addr_next   = r_addr;
    w_pend_next   = r_pend;
    w_wr_next     = 1'b0;
    w_ready_next  = 1'b0;
    w_done_next   = 1'b0;
    w_din_next    = DIN_A;
    w_addr_a_next = ADDR_A;
    w_count_next  = WORD_COUNT;
    w_issue       = 1'b0;
    w_src_data    = r_data;
    w_src_addr    = r_addr;
    w_src_mask    = r_pend;

    case (r_state)
      IDLE: begin
        w_ready_next = 1'b1;
        if (S_VALID && S_READY) begin
          w_ready_next = 1'b0;
          w_state_next = WRITE;
          w_data_next  = S_DATA;
          w_addr_next  = S_ADDR;
          w_issue      = 1'b1;
          w_src_data   = S_DATA;
          w_src_addr   = S_ADDR;
          w_src_mask   = S_MASK;
        end
      end
      WRITE: begin
        if (r_pend == '0) begin
          w_state_next = IDLE;
          w_ready_next = 1'b1;
          w_done_next  = 1'b1;
          w_count_next = WORD_COUNT + CNT_WIDTH'(1);
        end else begin
          w_issue = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_lane = lowest_set(w_src_mask);
    if (w_issue) begin
      w_pend_next = w_src_mask & ~(c_lane_one << w_lane);
      if (w_src_mask != '0) begin
        w_wr_next     = 1'b1;
        w_din_next    = w_src_data[w_lane*DATA_WIDTH_A +: DATA_WIDTH_A];
        w_addr_a_next = {2'b00, w_src_addr} + c_stride * ADDR_WIDTH'(w_lane);
      end
    end
  end

  assign W_A  = r_wr;
  assign EN_A = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_bram18_wide_writer.sv
`default_nettype none
// tb_bram18_wide_writer: randomized and directed requests, expected BRAM writes and
// DONE events queued at acceptance and checked by an independent monitor.
module tb_bram18_wide_writer;

  localparam int DW    = 18;
  localparam int LANES = 4;
  localparam int AW    = 11;
  localparam int BASE  = 512;
  localparam int DEPTH = 2048;
  // Narrow counter so the wrap-around is reached in a short run.
  localparam int CW    = 10;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [LANES*DW-1:0]   S_DATA;
  logic [AW-3:0]         S_ADDR;
  logic [LANES-1:0]      S_MASK;
  logic                  S_VALID;
  logic                  S_READY;
  logic [DW-1:0]         DIN_A;
  logic [AW-1:0]         ADDR_A;
  logic                  W_A;
  logic                  EN_A;
  logic                  DONE;
  logic [CW-1:0]         WORD_COUNT;

  bram18_wide_writer #(
    .DATA_WIDTH_A(DW), .LANES(LANES), .ADDR_WIDTH(AW),
    .BASE_ADDRESS(BASE), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_ADDR(S_ADDR), .S_MASK(S_MASK),
    .S_VALID(S_VALID), .S_READY(S_READY), .DIN_A(DIN_A), .ADDR_A(ADDR_A),
    .W_A(W_A), .EN_A(EN_A), .DONE(DONE), .WORD_COUNT(WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
  typedef struct { logic [CW-1:0] cnt; int cyc; } done_t;

  wr_t           exp_wr[$];
  done_t         exp_done[$];
  wr_t           mon_w;
  done_t         mon_d;
  logic [DW-1:0] mem [0:DEPTH-1];
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic [CW-1:0] model_cnt = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string why);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Reference: each set mask bit k, ascending, writes lane k at (addr + k*BASE) mod DEPTH
  // on consecutive cycles; DONE follows the last write (or one edge after an empty mask).
  task automatic push_expect(input logic [71:0] d, input logic [AW-3:0] a,
                             input logic [3:0] m, input int acc);
    int    i;
    done_t dn;
    i = 0;
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) begin
        wr_t w;
        w.addr = AW'((int'(a) + k * BASE) % DEPTH);
        w.data = d[DW*k +: DW];
        w.cyc  = acc + i;
        exp_wr.push_back(w);
        i++;
      end
    end
    model_cnt = model_cnt + 1'b1;
    dn.cnt = model_cnt;
    dn.cyc = acc + ((i == 0) ? 1 : i);
    exp_done.push_back(dn);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (EN_A || W_A) begin
        chk("en_vs_we", 72'(EN_A), 72'(W_A));
        if (exp_wr.size() == 0) flag("unexpected_write", "BRAM write with none pending");
        else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 72'(ADDR_A), 72'(mon_w.addr));
          chk("wr_data", 72'(DIN_A), 72'(mon_w.data));
          chk("wr_cycle", 72'(cyc), 72'(mon_w.cyc));
        end
        mem[ADDR_A] = DIN_A;
      end
      if (DONE) begin
        if (exp_done.size() == 0) flag("unexpected_done", "DONE with no word outstanding");
        else begin
          mon_d = exp_done.pop_front();
          chk("done_count", 72'(WORD_COUNT), 72'(mon_d.cnt));
          chk("done_cycle", 72'(cyc), 72'(mon_d.cyc));
          chk("done_ready", 72'(S_READY), 72'(1));
          chk("done_after_writes", 72'(exp_wr.size()), 72'(0));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send(input logic [71:0] d, input logic [AW-3:0] a, input logic [3:0] m,
                      input bit hold, output int acc);
    int guard;
    guard   = 0;
    S_DATA  = d;
    S_ADDR  = a;
    S_MASK  = m;
    S_VALID = 1'b1;
    while (!S_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!S_READY) begin
      flag("accept_timeout", "S_READY never rose");
      S_VALID = 1'b0;
      acc = -1;
      return;
    end
    @(posedge CLK);
    #1;
    acc = cyc;
    push_expect(d, a, m, acc);
    @(negedge CLK);
    chk("ready_low_after_accept", 72'(S_READY), 72'(0));
    if (!hold) S_VALID = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_done.size() != 0 && g < 40) begin
      @(negedge CLK);
      g++;
    end
    if (exp_done.size() != 0) flag(nm, "timed out waiting for DONE");
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ready"}, 72'(S_READY), 72'(0));
    chk({nm, "_din"},   72'(DIN_A),   72'(0));
    chk({nm, "_addr"},  72'(ADDR_A),  72'(0));
    chk({nm, "_we"},    72'(W_A),     72'(0));
    chk({nm, "_en"},    72'(EN_A),    72'(0));
    chk({nm, "_done"},  72'(DONE),    72'(0));
    chk({nm, "_count"}, 72'(WORD_COUNT), 72'(0));
  endtask

  function automatic logic [71:0] rand72();
    return {8'($urandom()), $urandom(), $urandom()};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          a1, a2, a3, acc, n;
    logic [71:0] word;
    logic [DW-1:0] sentinel;
    S_VALID = 1'b0;
    S_DATA  = '0;
    S_ADDR  = '0;
    S_MASK  = '0;
    RST     = 1'b1;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;
    chk("ready_at_release", 72'(S_READY), 72'(0));
    @(negedge CLK);
    chk("ready_first_edge", 72'(S_READY), 72'(1));

    // Full-mask word, then wide read from the modelled BRAM
    word = {18'h3FFFF, 18'h00001, 18'h2ABCD, 18'h15555};
    send(word, 9'd5, 4'hF, 1'b0, acc);
    drain("t1_done");
    chk("t1_count", 72'(WORD_COUNT), 72'(1));
    chk("t1_wide_read", {mem[1541], mem[1029], mem[517], mem[5]}, word);

    // Sparse mask leaves lanes 0 and 2 untouched
    sentinel = 18'h2D2D2;
    mem[0]    = sentinel;
    mem[1024] = sentinel;
    send(rand72(), 9'd0, 4'b1010, 1'b0, acc);
    drain("t2_done");
    chk("t2_lane0_untouched", 72'(mem[0]), 72'(sentinel));
    chk("t2_lane2_untouched", 72'(mem[1024]), 72'(sentinel));

    // Empty mask
    send(rand72(), 9'd33, 4'b0000, 1'b0, acc);
    drain("t3_done");
    chk("t3_count", 72'(WORD_COUNT), 72'(model_cnt));

    // Back-to-back with S_VALID held high
    send(rand72(), 9'd10, 4'hF, 1'b1, a1);
    send(rand72(), 9'd11, 4'hF, 1'b1, a2);
    send(rand72(), 9'd12, 4'hF, 1'b0, a3);
    chk("t4_spacing_1", 72'(a2 - a1), 72'(5));
    chk("t4_spacing_2", 72'(a3 - a2), 72'(5));
    drain("t4_done");
    chk("t4_count", 72'(WORD_COUNT), 72'(model_cnt));

    // Reset after the second lane write
    send(rand72(), 9'd7, 4'hF, 1'b0, acc);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check_zero("abort");
    chk("abort_pending", 72'(exp_wr.size()), 72'(2));
    exp_wr.delete();
    exp_done.delete();
    model_cnt = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_count", 72'(WORD_COUNT), 72'(0));

    // Top of the wide-address range, then counter wrap
    send(rand72(), 9'd511, 4'hF, 1'b0, acc);
    drain("t6_done");
    n = 0;
    while (model_cnt != CW'((1 << CW) - 1) && n < 2000) begin
      send(72'(0), 9'd0, 4'b0000, 1'b1, acc);
      n++;
    end
    send(72'(0), 9'd0, 4'b0000, 1'b0, acc);
    drain("wrap_done");
    chk("wrap_count", 72'(WORD_COUNT), 72'(0));

    // Randomized traffic
    for (int r = 0; r < 60; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        S_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
      end
      send(rand72(), 9'($urandom()), 4'($urandom()), 1'($urandom_range(0, 1)), acc);
    end
    S_VALID = 1'b0;
    drain("random_done");
    chk("final_writes_empty", 72'(exp_wr.size()), 72'(0));
    chk("final_count", 72'(WORD_COUNT), 72'(model_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
